// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and min:sec:centisec time base with lap snapshot,
// saturation at the top count and a blinking display enable while saturated.
module stopwatch_ctrl #(
   parameter int BLINK_TICKS = 50,
   parameter int MAX_MIN     = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       btn_ss,
   input  logic       btn_clr,
   input  logic       btn_lap,
   output logic [6:0] cs,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic       running,
   output logic       lap_active,
   output logic       disp_en
);

   localparam int            BW         = $clog2(BLINK_TICKS + 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
   localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
   localparam logic [5:0]    MIN_LAST   = 6'(MAX_MIN);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      MAXED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [6:0]    lcs_q, lcs_d, scs_q, scs_d, cs_q, cs_d;
   logic [5:0]    lsec_q, lsec_d, ssec_q, ssec_d, sec_q, sec_d;
   logic [5:0]    lmin_q, lmin_d, smin_q, smin_d, min_q, min_d;
   logic          lap_q, lap_d, disp_q, disp_d, running_q, running_d;
   logic [BW-1:0] blink_q, blink_d;
   logic          ss_s_q, ss_h_q, clr_s_q, clr_h_q, lap_s_q, lap_h_q;
   logic          clr_ev, ss_raw, ss_ev, lap_ev, at_top_m1;

   // Edge-detected button events, resolved by priority clr > ss > lap
   assign clr_ev    = clr_s_q & ~clr_h_q;
   assign ss_raw    = ss_s_q & ~ss_h_q;
   assign ss_ev     = ss_raw & ~clr_ev;
   assign lap_ev    = lap_s_q & ~lap_h_q & ~clr_ev & ~ss_raw;
   assign at_top_m1 = (lmin_q == MIN_LAST) && (lsec_q == 6'd59) && (lcs_q == 7'd98);

   // Next-state, counter, lap and blink logic
   always_comb begin
      state_d = state_q;
      lcs_d   = lcs_q;
      lsec_d  = lsec_q;
      lmin_d  = lmin_q;
      scs_d   = scs_q;
      ssec_d  = ssec_q;
      smin_d  = smin_q;
      lap_d   = lap_q;
      disp_d  = disp_q;
      blink_d = blink_q;
      if (clr_ev) begin
         state_d = IDLE;
         lcs_d   = 7'd0;
         lsec_d  = 6'd0;
         lmin_d  = 6'd0;
         scs_d   = 7'd0;
         ssec_d  = 6'd0;
         smin_d  = 6'd0;
         lap_d   = 1'b0;
         disp_d  = 1'b1;
         blink_d = BLINK_ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               if (ss_ev) state_d = RUN;
               else       state_d = IDLE;
            end
            RUN: begin
               // The snapshot takes the count as it stood before this edge's tick
               if (lap_ev && !lap_q) begin
                  scs_d  = lcs_q;
                  ssec_d = lsec_q;
                  smin_d = lmin_q;
                  lap_d  = 1'b1;
               end else if (lap_ev) begin
                  lap_d = 1'b0;
               end else begin
                  lap_d = lap_q;
               end
               if (tick && lcs_q == 7'd99) begin
                  lcs_d = 7'd0;
                  if (lsec_q == 6'd59) begin
                     lsec_d = 6'd0;
                     lmin_d = lmin_q + 6'd1;
                  end else begin
                     lsec_d = lsec_q + 6'd1;
                  end
               end else if (tick) begin
                  lcs_d = lcs_q + 7'd1;
               end else begin
                  lcs_d = lcs_q;
               end
               if (tick && at_top_m1) begin
                  state_d = MAXED;
                  lap_d   = 1'b0;
                  disp_d  = 1'b0;
                  blink_d = BLINK_ZERO;
               end else if (ss_ev) begin
                  state_d = PAUSE;
               end else begin
                  state_d = RUN;
               end
            end
            PAUSE: begin
               if (ss_ev)       state_d = RUN;
               else if (lap_ev) lap_d   = 1'b0;
               else             state_d = PAUSE;
            end
            MAXED: begin
               if (tick && blink_q == BLINK_LAST) begin
                  blink_d = BLINK_ZERO;
                  disp_d  = ~disp_q;
               end else if (tick) begin
                  blink_d = blink_q + BLINK_ONE;
               end else begin
                  blink_d = blink_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      cs_d      = lap_d ? scs_d  : lcs_d;
      sec_d     = lap_d ? ssec_d : lsec_d;
      min_d     = lap_d ? smin_d : lmin_d;
      running_d = (state_d == RUN);
   end

   // State, counters, button history and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lcs_q     <= 7'd0;
         lsec_q    <= 6'd0;
         lmin_q    <= 6'd0;
         scs_q     <= 7'd0;
         ssec_q    <= 6'd0;
         smin_q    <= 6'd0;
         cs_q      <= 7'd0;
         sec_q     <= 6'd0;
         min_q     <= 6'd0;
         lap_q     <= 1'b0;
         disp_q    <= 1'b1;
         running_q <= 1'b0;
         blink_q   <= BLINK_ZERO;
         ss_s_q    <= 1'b0;
         ss_h_q    <= 1'b0;
         clr_s_q   <= 1'b0;
         clr_h_q   <= 1'b0;
         lap_s_q   <= 1'b0;
         lap_h_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lcs_q     <= lcs_d;
         lsec_q    <= lsec_d;
         lmin_q    <= lmin_d;
         scs_q     <= scs_d;
         ssec_q    <= ssec_d;
         smin_q    <= smin_d;
         cs_q      <= cs_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         lap_q     <= lap_d;
         disp_q    <= disp_d;
         running_q <= running_d;
         blink_q   <= blink_d;
         ss_s_q    <= btn_ss;
         ss_h_q    <= ss_s_q;
         clr_s_q   <= btn_clr;
         clr_h_q   <= clr_s_q;
         lap_s_q   <= btn_lap;
         lap_h_q   <= lap_s_q;
      end
   end

   assign cs         = cs_q;
   assign sec        = sec_q;
   assign min        = min_q;
   assign running    = running_q;
   assign lap_active = lap_q;
   assign disp_en    = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random buttons/ticks,
// checked every cycle against an integer-centisecond reference model.
module tb_stopwatch_ctrl;

   localparam int BT   = 50;
   localparam int MM   = 2;
   localparam int MAXC = MM * 6000 + 5999;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_MAXED = 3;

   logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
   logic       btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
   logic [6:0] cs;
   logic [5:0] sec, min;
   logic       running, lap_active, disp_en;

   int errors = 0, checks = 0;
   int m_state, m_count, m_snap, m_blink;
   bit m_lap, m_disp;
   bit s_ss, h_ss, s_clr, h_clr, s_lap, h_lap;
   bit rss, rclr, rlap;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.BLINK_TICKS(BT), .MAX_MIN(MM)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .btn_ss(btn_ss), .btn_clr(btn_clr),
      .btn_lap(btn_lap), .cs(cs), .sec(sec), .min(min), .running(running),
      .lap_active(lap_active), .disp_en(disp_en)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_count = 0; m_snap = 0; m_blink = 0;
      m_lap = 1'b0; m_disp = 1'b1;
      s_ss = 0; h_ss = 0; s_clr = 0; h_clr = 0; s_lap = 0; h_lap = 0;
   endtask

   task automatic model_edge(input bit t, input bit e_ss, input bit e_clr, input bit e_lap);
      if (e_clr) begin
         m_state = M_IDLE; m_count = 0; m_snap = 0; m_lap = 1'b0; m_disp = 1'b1; m_blink = 0;
      end else if (m_state == M_IDLE) begin
         if (e_ss) m_state = M_RUN;
      end else if (m_state == M_RUN) begin
         if (e_lap) begin
            if (!m_lap) m_snap = m_count;
            m_lap = !m_lap;
         end
         if (t) begin
            m_count++;
            if (m_count == MAXC) begin
               m_state = M_MAXED; m_lap = 1'b0; m_disp = 1'b0; m_blink = 0;
            end
         end
         if (e_ss && m_state == M_RUN) m_state = M_PAUSE;
      end else if (m_state == M_PAUSE) begin
         if (e_ss) m_state = M_RUN;
         else if (e_lap) m_lap = 1'b0;
      end else if (t) begin
         m_blink++;
         if (m_blink == BT) begin
            m_blink = 0;
            m_disp = !m_disp;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int v;
      v = m_lap ? m_snap : m_count;
      chk({tag, ".cs"}, cs, v % 100);
      chk({tag, ".sec"}, sec, (v / 100) % 60);
      chk({tag, ".min"}, min, v / 6000);
      chk({tag, ".running"}, running, m_state == M_RUN);
      chk({tag, ".lap_active"}, lap_active, m_lap);
      chk({tag, ".disp_en"}, disp_en, m_disp);
   endtask

   task automatic step(input bit t, input bit ss, input bit clr, input bit lap);
      bit e_clr, e_ss, e_lap;
      @(negedge clk);
      tick = t; btn_ss = ss; btn_clr = clr; btn_lap = lap;
      e_clr = s_clr && !h_clr;
      e_ss  = s_ss && !h_ss && !e_clr;
      e_lap = s_lap && !h_lap && !e_clr && !(s_ss && !h_ss);
      @(posedge clk);
      model_edge(t, e_ss, e_clr, e_lap);
      h_ss = s_ss; s_ss = ss; h_clr = s_clr; s_clr = clr; h_lap = s_lap; s_lap = lap;
      #1 check_all("cyc");
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic press(input bit ss, input bit clr, input bit lap);
      step(1'b0, ss, clr, lap);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_time(input string tag, input int m, input int s, input int c);
      chk({tag, ".min"}, min, m);
      chk({tag, ".sec"}, sec, s);
      chk({tag, ".cs"}, cs, c);
   endtask

   initial begin
      model_reset();
      #12;
      chk_time("reset", 0, 0, 0);
      chk("reset.running", running, 0);
      chk("reset.lap", lap_active, 0);
      chk("reset.disp", disp_en, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // start, count, pause
      press(1, 0, 0);
      ticks(150);
      chk("t1.running", running, 1);
      chk_time("t1.run", 0, 1, 50);
      press(1, 0, 0);
      ticks(20);
      chk("t1.paused", running, 0);
      chk_time("t1.pause", 0, 1, 50);

      // carries and saturation
      press(1, 0, 0);
      ticks(5999 - 150);
      chk_time("t2.pre", 0, 59, 99);
      ticks(1);
      chk_time("t2.carry", 1, 0, 0);
      ticks(MAXC - 1 - 6000);
      chk_time("t2.top_m1", MM, 59, 98);
      ticks(1);
      chk_time("t2.top", MM, 59, 99);
      chk("t2.running", running, 0);
      chk("t2.disp", disp_en, 0);

      // blink then clear
      ticks(49);
      chk("t3.disp49", disp_en, 0);
      ticks(1);
      chk("t3.disp50", disp_en, 1);
      ticks(50);
      chk("t3.disp100", disp_en, 0);
      chk_time("t3.held", MM, 59, 99);
      press(1, 0, 1);
      chk("t3.ignored", disp_en, 0);
      press(0, 1, 0);
      chk_time("t3.clr", 0, 0, 0);
      chk("t3.disp", disp_en, 1);
      chk("t3.running", running, 0);

      // lap freeze and release
      press(1, 0, 0);
      ticks(1000);
      press(0, 0, 1);
      chk("t4.lap_on", lap_active, 1);
      chk_time("t4.frozen", 0, 10, 0);
      ticks(300);
      chk_time("t4.still", 0, 10, 0);
      press(0, 0, 1);
      chk("t4.lap_off", lap_active, 0);
      chk_time("t4.live", 0, 13, 0);

      // same-cycle priority and tick+ss
      press(1, 1, 1);
      chk("t5.running", running, 0);
      chk("t5.lap", lap_active, 0);
      chk_time("t5.clr", 0, 0, 0);
      press(1, 0, 0);
      ticks(5);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t5.pause", running, 0);
      chk_time("t5.count", 0, 0, 6);

      // held button gives one event; async reset mid-run
      press(0, 1, 0);
      repeat (100) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6.one_event", running, 1);
      ticks(7);
      chk_time("t6.run", 0, 0, 7);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_time("t6.arst", 0, 0, 0);
      chk("t6.arst.running", running, 0);
      chk("t6.arst.lap", lap_active, 0);
      chk("t6.arst.disp", disp_en, 1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // random buttons and ticks
      rss = 0; rclr = 0; rlap = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) rss = ~rss;
         if ($urandom_range(0, 9) == 0) rlap = ~rlap;
         if ($urandom_range(0, 199) == 0) rclr = ~rclr;
         step(1'($urandom_range(0, 1)), rss, rclr, rlap);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
